// File: rtl/ifetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_queue_pkg
// Shared types and constants for the instruction prefetch queue:
//   - fetch_state_e : fetch FSM states (IDLE, REQ, DRAIN)
//   - INSTR_W       : instruction / address width
//   - PC_INC        : sequential fetch stride in bytes
//   - fetch_entry_t : one queued word together with the PC it was fetched from
// ----------------------------------------------------------------------------
package ifetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_fifo.sv
// ----------------------------------------------------------------------------
// ifq_fifo
// Synchronous FIFO of fetch entries with push, pop and flush.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_push, i_push_data  write one entry (ignored when full or flushing)
//   i_pop            remove the head entry (ignored when empty or flushing)
//   i_flush          empty the FIFO; overrides a same-cycle push/pop
//   o_head           head entry, all zeros while empty
//   o_count, o_full, o_empty  occupancy status
// ----------------------------------------------------------------------------
module ifq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  fetch_entry_t  i_push_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PONE_C  = {{(PW-1){1'b0}}, 1'b1};

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_count   = r_count;
    assign o_full    = (r_count == DEPTH_C);
    assign o_empty   = (r_count == {CW{1'b0}});
    assign w_push_ok = i_push & ~o_full  & ~i_flush;
    assign w_pop_ok  = i_pop  & ~o_empty & ~i_flush;
    // Masking the head keeps stale storage from leaking onto the outputs.
    assign o_head    = o_empty ? fetch_entry_t'(64'd0) : r_mem[r_rd_ptr];

    // Entry storage; contents are only observed through the masked head.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PONE_C;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PONE_C;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
// Instruction prefetch stage: owns the fetch PC, issues one word request at a
// time on a req/ack port, queues returned words with their PCs and hands them
// to decode on a valid/ready handshake. Redirects flush the queue and discard
// any response still in flight.
// Ports:
//   i_clk, i_rst_n                clock, synchronous active-low reset
//   o_imem_req, o_imem_addr       word request (held stable until ack)
//   i_imem_ack, i_imem_rdata      response strobe and data
//   i_redirect, i_redirect_pc     taken branch/jump and its target
//   o_valid, o_instr, o_pc        queue head towards decode
//   i_ready                       decode accepts the head
// ----------------------------------------------------------------------------
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int                 DEPTH    = 4,
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_imem_req,
    output logic [INSTR_W-1:0] o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    input  logic               i_redirect,
    input  logic [INSTR_W-1:0] i_redirect_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [INSTR_W-1:0] o_pc,
    input  logic               i_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [INSTR_W-1:0] r_pc;
    logic [INSTR_W-1:0] w_pc_next;
    logic [INSTR_W-1:0] r_addr;
    logic [INSTR_W-1:0] w_addr_next;
    logic               r_req;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic [CW-1:0]      w_count;
    logic [CW:0]        w_count_after;
    logic               w_full;
    logic               w_empty;
    logic [INSTR_W-1:0] w_redirect_pc;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_data;

    assign w_redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;
    assign w_pop         = ~w_empty & i_ready;
    assign w_push_data   = '{pc: r_pc, instr: i_imem_rdata};
    // Occupancy after this cycle's push and pop, one bit wider to avoid wrap.
    assign w_count_after = {1'b0, w_count} + {{CW{1'b0}}, 1'b1} - {{CW{1'b0}}, w_pop};

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign o_valid     = ~w_empty;
    assign o_instr     = w_head.instr;
    assign o_pc        = w_head.pc;
    assign o_imem_req  = r_req;
    assign o_imem_addr = r_addr;

    // Fetch FSM next state, PC update and FIFO control; redirect beats ack.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_redirect) begin
                    w_flush      = 1'b1;
                    w_pc_next    = w_redirect_pc;
                    w_state_next = ST_REQ;
                end else if (!w_full) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_redirect) begin
                    w_flush      = 1'b1;
                    w_pc_next    = w_redirect_pc;
                    // Without the ack the old response is still owed: drain it.
                    w_state_next = i_imem_ack ? ST_REQ : ST_DRAIN;
                end else if (i_imem_ack) begin
                    w_push       = 1'b1;
                    w_pc_next    = r_pc + PC_INC;
                    w_state_next = (w_count_after < DEPTH_X) ? ST_REQ : ST_IDLE;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (i_redirect) begin
                    w_flush      = 1'b1;
                    w_pc_next    = w_redirect_pc;
                    // An ack alongside the redirect still retires the old request.
                    w_state_next = i_imem_ack ? ST_REQ : ST_DRAIN;
                end else if (i_imem_ack) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: begin
                w_flush      = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
        // DRAIN must keep presenting the abandoned address until its ack.
        w_addr_next = (w_state_next == ST_DRAIN) ? r_addr : w_pc_next;
    end

    // State, PC and registered memory-port outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_addr  <= w_addr_next;
            r_req   <= (w_state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
    import ifetch_queue_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready;

    int n_cmp;
    int n_fail;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .i_ready       (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mk(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Zero-wait memory: acknowledge whatever is requested this cycle.
    task automatic auto_cyc();
        i_imem_ack   = o_imem_req;
        i_imem_rdata = mk(o_imem_addr);
        tick();
        i_imem_ack   = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0; i_imem_ack = 1'b0; i_redirect = 1'b0;
        i_redirect_pc = 32'h0; i_ready = 1'b0; i_imem_rdata = 32'h0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;

        // Reset state
        do_reset();
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_req", {31'd0, o_imem_req}, 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_pc", o_pc, 32'd0);

        // Streaming with zero-wait memory
        i_ready = 1'b1;
        auto_cyc();
        chk("s1_req", {31'd0, o_imem_req}, 32'd1);
        chk("s1_addr", o_imem_addr, 32'h0);
        chk("s1_valid", {31'd0, o_valid}, 32'd0);
        auto_cyc();
        chk("s2_valid", {31'd0, o_valid}, 32'd1);
        chk("s2_pc", o_pc, 32'h0);
        chk("s2_instr", o_instr, mk(32'h0));
        chk("s2_addr", o_imem_addr, 32'h4);
        auto_cyc();
        chk("s3_pc", o_pc, 32'h4);
        chk("s3_addr", o_imem_addr, 32'h8);
        auto_cyc();
        chk("s4_pc", o_pc, 32'h8);
        chk("s4_instr", o_instr, mk(32'h8));

        // Fill to DEPTH with decode stalled
        do_reset();
        for (int i = 0; i < 5; i++) auto_cyc();
        chk("full_count", 32'(dut.w_count), 32'd4);
        chk("full_req", {31'd0, o_imem_req}, 32'd0);
        chk("full_addr", o_imem_addr, 32'h10);
        chk("full_pc", o_pc, 32'h0);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("pop_count", 32'(dut.w_count), 32'd3);
        chk("pop_pc", o_pc, 32'h4);
        for (int k = 0; k < 4 && !o_imem_req; k++) tick();
        chk("reissue_req", {31'd0, o_imem_req}, 32'd1);
        chk("reissue_addr", o_imem_addr, 32'h10);

        // Redirect while the 0x8 request waits
        do_reset();
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) auto_cyc();
        chk("rd_pre_addr", o_imem_addr, 32'h8);
        i_redirect = 1'b1; i_redirect_pc = 32'h40;
        tick();
        i_redirect = 1'b0;
        chk("rd_flush_valid", {31'd0, o_valid}, 32'd0);
        chk("rd_state", 32'(dut.r_state), 32'(ST_DRAIN));
        chk("rd_hold_addr", o_imem_addr, 32'h8);
        tick();
        chk("rd_wait_valid", {31'd0, o_valid}, 32'd0);
        i_imem_ack = 1'b1; i_imem_rdata = mk(32'h8);
        tick();
        i_imem_ack = 1'b0;
        chk("rd_drop_valid", {31'd0, o_valid}, 32'd0);
        chk("rd_new_addr", o_imem_addr, 32'h40);
        auto_cyc();
        chk("rd_valid", {31'd0, o_valid}, 32'd1);
        chk("rd_pc", o_pc, 32'h40);
        chk("rd_instr", o_instr, mk(32'h40));

        // Redirect coincident with ack for 0xC
        do_reset();
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) auto_cyc();
        chk("ra_pre_pc", o_pc, 32'h8);
        chk("ra_pre_addr", o_imem_addr, 32'hC);
        i_imem_ack = 1'b1; i_imem_rdata = mk(32'hC);
        i_redirect = 1'b1; i_redirect_pc = 32'h83;
        tick();
        i_imem_ack = 1'b0; i_redirect = 1'b0;
        chk("ra_valid0", {31'd0, o_valid}, 32'd0);
        chk("ra_addr", o_imem_addr, 32'h80);
        chk("ra_req", {31'd0, o_imem_req}, 32'd1);
        tick();
        chk("ra_valid1", {31'd0, o_valid}, 32'd0);
        i_imem_ack = 1'b1; i_imem_rdata = mk(32'h80);
        tick();
        i_imem_ack = 1'b0;
        chk("ra_valid2", {31'd0, o_valid}, 32'd1);
        chk("ra_pc", o_pc, 32'h80);

        // Push and pop at count=2 across pointer wrap
        do_reset();
        for (int i = 0; i < 3; i++) auto_cyc();
        chk("pp_count0", 32'(dut.w_count), 32'd2);
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            auto_cyc();
            chk("pp_count", 32'(dut.w_count), 32'd2);
            chk("pp_pc", o_pc, 32'(4 * (i + 1)));
            chk("pp_instr", o_instr, mk(32'(4 * (i + 1))));
        end

        // Reset in DRAIN, stale ack just after release
        do_reset();
        i_ready = 1'b1;
        auto_cyc();
        i_redirect = 1'b1; i_redirect_pc = 32'h200;
        tick();
        i_redirect = 1'b0;
        chk("rdr_state", 32'(dut.r_state), 32'(ST_DRAIN));
        i_rst_n = 1'b0;
        tick();
        chk("rdr_req", {31'd0, o_imem_req}, 32'd0);
        chk("rdr_valid", {31'd0, o_valid}, 32'd0);
        i_rst_n = 1'b1;
        i_imem_ack = 1'b1; i_imem_rdata = mk(32'h200);
        tick();
        i_imem_ack = 1'b0;
        chk("rdr_req1", {31'd0, o_imem_req}, 32'd1);
        chk("rdr_addr", o_imem_addr, 32'h0);
        chk("rdr_valid1", {31'd0, o_valid}, 32'd0);
        tick();
        chk("rdr_valid2", {31'd0, o_valid}, 32'd0);
        auto_cyc();
        chk("rdr_valid3", {31'd0, o_valid}, 32'd1);
        chk("rdr_pc", o_pc, 32'h0);
        chk("rdr_instr", o_instr, mk(32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
